// File: rtl/datapath_sequencer_if.sv
// Instruction handshake plus every datapath control driven by the sequencer.
interface datapath_sequencer_if;
  logic        start;
  logic [15:0] instr;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic        write;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  modport master (
    output start, instr,
    input  busy, done, err, readnum, writenum, loada, loadb, loadc, loads,
           asel, bsel, vsel, write, shift, ALUop, datapath_in
  );

  modport slave (
    input  start, instr,
    output busy, done, err, readnum, writenum, loada, loadb, loadc, loads,
           asel, bsel, vsel, write, shift, ALUop, datapath_in
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM: captures one instruction, then sequences operand
// fetch, execute and writeback on the downstream datapath.
module datapath_sequencer (
  input logic                  clk,
  input logic                  rst_n,
  datapath_sequencer_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LA   = 3'd1;
  localparam logic [2:0] LB   = 3'd2;
  localparam logic [2:0] EX   = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] WIMM = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  // Entry state per {opcode, op}; illegal encodings jump straight to DONE.
  function automatic logic [2:0] first_state(input logic [4:0] code);
    case (code)
      5'b110_10:                     first_state = WIMM;
      5'b110_00, 5'b101_11:          first_state = LB;
      5'b101_00, 5'b101_01, 5'b101_10: first_state = LA;
      default:                       first_state = DONE;
    endcase
  endfunction

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ir;
  logic        is_movr;
  logic        is_cmp;
  logic        is_mvn;
  logic        legal;

  assign is_movr = (ir[15:11] == 5'b110_00);
  assign is_cmp  = (ir[15:11] == 5'b101_01);
  assign is_mvn  = (ir[15:11] == 5'b101_11);
  assign legal   = (first_state(ir[15:11]) != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start)
        ir <= bus.instr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start) state_nxt = first_state(bus.instr[15:11]);
      LA:        state_nxt = LB;
      LB:        state_nxt = EX;
      EX:        state_nxt = is_cmp ? DONE : WR;
      WR, WIMM:  state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.err         = (state == DONE) && !legal;
  assign bus.datapath_in = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.vsel     = 1'b0;
    bus.write    = 1'b0;
    bus.shift    = '0;
    bus.ALUop    = '0;
    case (state)
      LA: begin
        bus.readnum = ir[10:8];
        bus.loada   = 1'b1;
      end
      LB: begin
        bus.readnum = ir[2:0];
        bus.loadb   = 1'b1;
      end
      EX: begin
        bus.shift = ir[4:3];
        bus.asel  = is_movr || is_mvn;
        bus.ALUop = is_movr ? 2'b00 : (is_cmp ? 2'b01 : ir[12:11]);
        bus.loadc = !is_cmp;
        bus.loads = is_cmp;
      end
      WR: begin
        bus.writenum = ir[7:5];
        bus.write    = 1'b1;
      end
      WIMM: begin
        bus.writenum = ir[10:8];
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle control FSM that sits directly upstream of `datapath` and replaces manual switch-driven control. It accepts one 16-bit instruction through a start/done handshake, decodes it, and drives every datapath control input in sequence: operand fetch, execute, writeback. It also supplies `datapath_in` with the sign-extended immediate, so a complete register-to-register or immediate operation needs no operator action between clock edges.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock, shared with `datapath`.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to execute `instr`. Sampled only in IDLE.
- `instr` input 16: instruction word, captured on the edge that accepts `start`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse, high in the DONE state.
- `err` output 1: high in DONE when the captured opcode was illegal, otherwise 0.
- `readnum`, `writenum` output 3 each: register-file read and write addresses.
- `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `vsel`, `write` output 1 each: datapath controls. `vsel`=1 selects `datapath_in`; `vsel`=0 selects C.
- `shift`, `ALUop` output 2 each: shifter and ALU controls.
- `datapath_in` output 16: `{{8{ir[7]}}, ir[7:0]}`, driven continuously from the instruction register.

## Operation
- Instruction register `ir` fields:
  - `[15:13]` opcode, `[12:11]` op.
  - `[10:8]` Rn, `[7:5]` Rd, `[4:3]` sh, `[2:0]` Rm.
  - `[7:0]` imm8.
- Legal encodings:
  - opcode 110, op 10: MOV Rn,#imm8.
  - opcode 110, op 00: MOV Rd,Rm{sh}.
  - opcode 101, op 00: ADD Rd,Rn,Rm{sh}.
  - opcode 101, op 01: CMP Rn,Rm{sh}.
  - opcode 101, op 10: AND Rd,Rn,Rm{sh}.
  - opcode 101, op 11: MVN Rd,Rm{sh}.
  - Every other opcode/op combination is illegal.
- States: IDLE, LA, LB, EX, WR, WIMM, DONE. Outputs are Moore, decoded from state and `ir`. Any control not listed for a state is 0.
  - LA: `readnum`=Rn, `loada`=1.
  - LB: `readnum`=Rm, `loadb`=1.
  - EX: `shift`=sh, `bsel`=0, `asel`=1 for MOV-reg and MVN, else 0.
    - MOV-reg: `ALUop`=00. CMP: `ALUop`=01. All other ops: `ALUop`=op.
    - `loadc`=1 for everything except CMP. CMP asserts `loads`=1, `loadc`=0.
  - WR: `writenum`=Rd, `vsel`=0, `write`=1.
  - WIMM: `writenum`=Rn, `vsel`=1, `write`=1.
- State sequences:
  - MOV-imm: IDLE→WIMM→DONE.
  - MOV-reg, MVN: IDLE→LB→EX→WR→DONE.
  - ADD, AND: IDLE→LA→LB→EX→WR→DONE.
  - CMP: IDLE→LA→LB→EX→DONE.
  - Illegal: IDLE→DONE with `err`=1; no control asserted at any point.
- DONE→IDLE unconditionally.
- `start` outside IDLE is ignored; `ir` does not change.
- In IDLE with `start`=0, `ir` holds its value, so `datapath_in` stays stable.

## Timing
- Reset (asynchronous, immediate, any state):
  - state=IDLE, `ir`=0.
  - All control outputs, `busy`, `done`, `err` = 0; `datapath_in`=0.
  - Reset mid-operation aborts it with no further `write`, `loadc` or `loads`.
- Edge numbering: edge 0 is the edge that accepts `start`. Cycle n is the cycle following edge n-1, so cycle 1 follows edge 0.
  - The first active state occupies cycle 1.
  - `busy` rises in cycle 1.
  - DONE cycle:
    - MOV-imm: cycle 2.
    - MOV-reg, MVN: cycle 4.
    - CMP: cycle 4.
    - ADD, AND: cycle 5.
    - Illegal: cycle 1.
  - IDLE again one cycle after DONE. The earliest next acceptance is at the edge ending the first IDLE cycle.
- Each control is high for exactly one cycle per instruction. The datapath register it targets updates on the rising edge ending that cycle.
- `start` held high continuously:
  - A new instruction is accepted at every IDLE cycle.
  - Back-to-back throughput is latency+1 cycles.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle in EX of ADD. Outputs drop to 0 asynchronously, the register file is unchanged, and `busy`=0 after release.
- **MOV-imm:** `instr`=0xD0FD with `start`. Cycle 1: `write`=1, `vsel`=1, `writenum`=0, `datapath_in`=0xFFFD. Cycle 2: `done`=1; R0 reads back 0xFFFD.
- **ADD:** R1=5, R0=0xFFFD, `instr`=0xA140. Cycles 1–4 show LA(1), LB(0), EX(`ALUop`=00, `loadc`), WR(`writenum`=2). `done` in cycle 5; R2=0x0002.
- **CMP:** R1=R0=7, `instr`=0xA900. EX asserts `loads`=1 and `loadc`=0; no `write` occurs. `done` in cycle 4; `Z_out`=1.
- **MVN and MOV-reg with shift:**
  - `instr`=0xB869 with R1=0x0003: EX shows `asel`=1, `shift`=01, `ALUop`=11. R3=0xFFF9.
  - Then `instr`=0xC092: R4=R2>>1.
- **Illegal opcode and busy-start:**
  - `instr`=0x0000: `done`=`err`=1 in cycle 1, with no `write`/`loadc`/`loads`.
  - A `start` pulse with a different `instr` during an ADD's LB state is ignored; the ADD result is unaffected.
